// File: rtl/image_op_scheduler.sv
// Sequences the mirror / grayscale / sharpness engines over one shared image memory,
// with a per-operation watchdog, RUN-cycle accounting and a registered memory bus mux.
module image_op_scheduler #(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned PIX_W   = 24,
  parameter int unsigned TIMEOUT = 20000,
  parameter int unsigned CNT_W   = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op_mask,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_op,
  output logic [CNT_W-1:0]      op_cycles,
  output logic [2:0]            eng_start,
  input  logic [2:0]            eng_done,
  input  logic [3*ADDR_W-1:0]   eng_row,
  input  logic [3*ADDR_W-1:0]   eng_col,
  input  logic [2:0]            eng_we,
  input  logic [3*PIX_W-1:0]    eng_pix,
  output logic [ADDR_W-1:0]     mem_row,
  output logic [ADDR_W-1:0]     mem_col,
  output logic                  mem_we,
  output logic [PIX_W-1:0]      mem_pix
);

  localparam int unsigned WD_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_LAUNCH, S_RUN, S_FINISH, S_FAULT
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          pending_q, pending_d;
  logic [1:0]          cur_q, cur_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [1:0]          err_op_q, err_op_d;
  logic [CNT_W-1:0]    op_cycles_q, op_cycles_d;
  logic [2:0]          eng_start_q, eng_start_d;
  logic [ADDR_W-1:0]   mem_row_q, mem_row_d;
  logic [ADDR_W-1:0]   mem_col_q, mem_col_d;
  logic                mem_we_q, mem_we_d;
  logic [PIX_W-1:0]    mem_pix_q, mem_pix_d;

  logic [2:0]          cur_oh;
  logic [2:0]          cur_oh_d;
  logic                cur_done;
  logic                wd_expired;
  logic [ADDR_W-1:0]   sel_row, sel_col;
  logic [PIX_W-1:0]    sel_pix;

  assign cur_oh     = 3'b001 << cur_q;
  assign cur_done   = |(eng_done & cur_oh);
  assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));

  // Only the current engine's bus is ever visible to the memory
  always_comb begin
    sel_row = eng_row[0 +: ADDR_W];
    sel_col = eng_col[0 +: ADDR_W];
    sel_pix = eng_pix[0 +: PIX_W];
    case (cur_q)
      2'd1: begin
        sel_row = eng_row[ADDR_W +: ADDR_W];
        sel_col = eng_col[ADDR_W +: ADDR_W];
        sel_pix = eng_pix[PIX_W +: PIX_W];
      end
      2'd2: begin
        sel_row = eng_row[2*ADDR_W +: ADDR_W];
        sel_col = eng_col[2*ADDR_W +: ADDR_W];
        sel_pix = eng_pix[2*PIX_W +: PIX_W];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Engine done is checked ahead of the watchdog so a done on the expiry cycle wins
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_SELECT;
      S_SELECT: state_d = (pending_q == 3'b000) ? S_FINISH : S_LAUNCH;
      S_LAUNCH: state_d = S_RUN;
      S_RUN: begin
        if (cur_done)        state_d = S_SELECT;
        else if (wd_expired) state_d = S_FAULT;
      end
      S_FINISH: state_d = S_IDLE;
      S_FAULT:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pending_d   = pending_q;
    cur_d       = cur_q;
    wd_d        = wd_q;
    error_d     = error_q;
    err_op_d    = err_op_q;
    op_cycles_d = op_cycles_q;
    mem_row_d   = mem_row_q;
    mem_col_d   = mem_col_q;
    mem_pix_d   = mem_pix_q;
    mem_we_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pending_d   = op_mask;
          error_d     = 1'b0;
          err_op_d    = 2'd0;
          op_cycles_d = '0;
        end
      end
      S_SELECT: begin
        if (pending_q[0])      cur_d = 2'd0;
        else if (pending_q[1]) cur_d = 2'd1;
        else if (pending_q[2]) cur_d = 2'd2;
      end
      S_LAUNCH: begin
        pending_d = pending_q & ~cur_oh;
        wd_d      = '0;
      end
      S_RUN: begin
        op_cycles_d = (&op_cycles_q) ? op_cycles_q : op_cycles_q + CNT_W'(1);
        wd_d        = wd_q + WD_W'(1);
        mem_row_d   = sel_row;
        mem_col_d   = sel_col;
        mem_pix_d   = sel_pix;
        mem_we_d    = |(eng_we & cur_oh);
      end
      S_FAULT:  pending_d = 3'b000;
      default: ;
    endcase
    if (state_d == S_FAULT) begin
      error_d  = 1'b1;
      err_op_d = cur_q;
    end
    cur_oh_d    = 3'b001 << cur_d;
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_FINISH);
    eng_start_d = (state_d == S_LAUNCH) ? cur_oh_d : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= 3'b000;
      cur_q       <= 2'd0;
      wd_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_op_q    <= 2'd0;
      op_cycles_q <= '0;
      eng_start_q <= 3'b000;
      mem_row_q   <= '0;
      mem_col_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_pix_q   <= '0;
    end else begin
      pending_q   <= pending_d;
      cur_q       <= cur_d;
      wd_q        <= wd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_op_q    <= err_op_d;
      op_cycles_q <= op_cycles_d;
      eng_start_q <= eng_start_d;
      mem_row_q   <= mem_row_d;
      mem_col_q   <= mem_col_d;
      mem_we_q    <= mem_we_d;
      mem_pix_q   <= mem_pix_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_op    = err_op_q;
  assign op_cycles = op_cycles_q;
  assign eng_start = eng_start_q;
  assign mem_row   = mem_row_q;
  assign mem_col   = mem_col_q;
  assign mem_we    = mem_we_q;
  assign mem_pix   = mem_pix_q;

endmodule

// File: tb/tb_image_op_scheduler.sv
// Bench for image_op_scheduler: table of commands plus random commands, each checked cycle by
// cycle against a timeline model built from the sequencing rules; directed mux and reset cases.
module tb_image_op_scheduler;

  localparam int unsigned AW = 6;
  localparam int unsigned PW = 24;
  localparam int unsigned TO = 50;
  localparam int unsigned CW = 6;
  localparam int SATV = (1 << CW) - 1;

  localparam int P_IDLE = 0, P_SEL = 1, P_LAU = 2, P_RUN = 3, P_FIN = 4, P_FAULT = 5;

  logic            clk, rst, start;
  logic [2:0]      op_mask;
  logic            busy, done, error;
  logic [1:0]      err_op;
  logic [CW-1:0]   op_cycles;
  logic [2:0]      eng_start, eng_done, eng_we;
  logic [3*AW-1:0] eng_row, eng_col;
  logic [3*PW-1:0] eng_pix;
  logic [AW-1:0]   mem_row, mem_col;
  logic            mem_we;
  logic [PW-1:0]   mem_pix;

  image_op_scheduler #(.ADDR_W(AW), .PIX_W(PW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .op_mask(op_mask),
    .busy(busy), .done(done), .error(error), .err_op(err_op), .op_cycles(op_cycles),
    .eng_start(eng_start), .eng_done(eng_done), .eng_row(eng_row), .eng_col(eng_col),
    .eng_we(eng_we), .eng_pix(eng_pix),
    .mem_row(mem_row), .mem_col(mem_col), .mem_we(mem_we), .mem_pix(mem_pix)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  bit            exp_err;
  int            exp_errop, exp_opc;
  logic [AW-1:0] exp_mrow, exp_mcol;
  logic [PW-1:0] exp_mpix;
  logic          exp_mwe;

  typedef struct {
    logic [2:0] mask;
    int lat0, lat1, lat2;   // 0 = engine never reports done
    int opc;
    bit err;
    int errop;
  } vec_t;

  task automatic chk(input string nm, input int c, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, c, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_bus();
    eng_row = 18'($urandom);
    eng_col = 18'($urandom);
    eng_pix = 72'({$urandom, $urandom, $urandom});
    eng_we  = 3'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b1;
    op_mask = 3'b111;
    eng_done = 3'b111;
    rand_bus();
    step();
    chk("rst_busy", 0, 64'(busy), 64'd0);
    chk("rst_done", 0, 64'(done), 64'd0);
    chk("rst_error", 0, 64'(error), 64'd0);
    chk("rst_err_op", 0, 64'(err_op), 64'd0);
    chk("rst_op_cycles", 0, 64'(op_cycles), 64'd0);
    chk("rst_eng_start", 0, 64'(eng_start), 64'd0);
    chk("rst_mem_we", 0, 64'(mem_we), 64'd0);
    chk("rst_mem_row", 0, 64'(mem_row), 64'd0);
    chk("rst_mem_col", 0, 64'(mem_col), 64'd0);
    chk("rst_mem_pix", 0, 64'(mem_pix), 64'd0);
    rst = 1'b0;
    start = 1'b0;
    eng_done = 3'b000;
    step();
    chk("post_rst_eng_start", 1, 64'(eng_start), 64'd0);
    chk("post_rst_busy", 1, 64'(busy), 64'd0);
    exp_err = 0; exp_errop = 0; exp_opc = 0;
    exp_mrow = '0; exp_mcol = '0; exp_mpix = '0; exp_mwe = 1'b0;
  endtask

  // Builds the expected phase timeline of a command, then drives and checks it cycle by cycle
  task automatic run_cmd(input logic [2:0] mask, input int l0, input int l1, input int l2);
    int ph[$];
    int eg[$];
    bit dn[$];
    int lt[3];
    bit to_hit;
    bit e_err;
    int e_eop, runs, n;
    lt[0] = l0; lt[1] = l1; lt[2] = l2;
    to_hit = 0;
    ph.push_back(P_IDLE); eg.push_back(0); dn.push_back(0);
    for (int i = 0; i < 3; i++) begin
      if (mask[i] && !to_hit) begin
        bit tmo;
        int r;
        tmo = (lt[i] == 0) || (lt[i] > int'(TO));
        r = tmo ? int'(TO) : lt[i];
        ph.push_back(P_SEL); eg.push_back(i); dn.push_back(0);
        ph.push_back(P_LAU); eg.push_back(i); dn.push_back(0);
        for (int k = 0; k < r; k++) begin
          ph.push_back(P_RUN); eg.push_back(i); dn.push_back(!tmo && k == r - 1);
        end
        if (tmo) begin
          ph.push_back(P_FAULT); eg.push_back(i); dn.push_back(0);
          to_hit = 1;
        end
      end
    end
    if (!to_hit) begin
      ph.push_back(P_SEL); eg.push_back(0); dn.push_back(0);
      ph.push_back(P_FIN); eg.push_back(0); dn.push_back(0);
    end
    ph.push_back(P_IDLE); eg.push_back(0); dn.push_back(0);
    n = ph.size();
    e_err = exp_err; e_eop = exp_errop; runs = 0;
    for (int c = 0; c < n; c++) begin
      logic [2:0] es, d;
      int opc_e;
      if (c == 1) begin e_err = 0; e_eop = 0; end
      if (ph[c] == P_FAULT) begin e_err = 1; e_eop = eg[c]; end
      es = (ph[c] == P_LAU) ? 3'(1 << eg[c]) : 3'b000;
      opc_e = (c == 0) ? exp_opc : ((runs > SATV) ? SATV : runs);
      chk("busy", c, 64'(busy), 64'(ph[c] != P_IDLE));
      chk("done", c, 64'(done), 64'(ph[c] == P_FIN));
      chk("eng_start", c, 64'(eng_start), 64'(es));
      chk("error", c, 64'(error), 64'(e_err));
      chk("err_op", c, 64'(err_op), 64'(e_eop));
      chk("op_cycles", c, 64'(op_cycles), 64'(opc_e));
      chk("mem_we", c, 64'(mem_we), 64'(exp_mwe));
      chk("mem_row", c, 64'(mem_row), 64'(exp_mrow));
      chk("mem_col", c, 64'(mem_col), 64'(exp_mcol));
      chk("mem_pix", c, 64'(mem_pix), 64'(exp_mpix));
      rand_bus();
      if (c == 0) begin
        start = 1'b1; op_mask = mask;
      end else if (c == n - 1) begin
        start = 1'b0; op_mask = 3'($urandom);
      end else begin
        start = 1'($urandom); op_mask = 3'($urandom);
      end
      d = 3'($urandom);
      if (ph[c] == P_RUN) d[eg[c]] = dn[c];
      eng_done = d;
      if (ph[c] == P_RUN) begin
        exp_mrow = eng_row[eg[c]*AW +: AW];
        exp_mcol = eng_col[eg[c]*AW +: AW];
        exp_mpix = eng_pix[eg[c]*PW +: PW];
        exp_mwe  = eng_we[eg[c]];
        runs++;
      end else begin
        exp_mwe = 1'b0;
      end
      step();
    end
    exp_err = e_err; exp_errop = e_eop;
    exp_opc = (runs > SATV) ? SATV : runs;
  endtask

  initial begin
    vec_t tbl[10];
    tbl[0] = '{3'b111, 10, 20, 30, 60, 1'b0, 0};
    tbl[1] = '{3'b101,  5,  7,  9, 14, 1'b0, 0};
    tbl[2] = '{3'b000,  1,  1,  1,  0, 1'b0, 0};
    tbl[3] = '{3'b010,  4,  0,  4, 50, 1'b1, 1};
    tbl[4] = '{3'b111,  3,  0,  4, 53, 1'b1, 1};
    tbl[5] = '{3'b111, 30, 30, 30, 63, 1'b0, 0};
    tbl[6] = '{3'b100,  9,  9,  1,  1, 1'b0, 0};
    tbl[7] = '{3'b001, 50,  1,  1, 50, 1'b0, 0};
    tbl[8] = '{3'b001, 51,  1,  1, 50, 1'b1, 0};
    tbl[9] = '{3'b100,  1,  1,  0, 50, 1'b1, 2};

    rst = 1'b1; start = 1'b0; op_mask = 3'b000;
    eng_done = 3'b000; eng_we = 3'b000; eng_row = '0; eng_col = '0; eng_pix = '0;
    step();
    do_reset();

    for (int t = 0; t < 10; t++) begin
      run_cmd(tbl[t].mask, tbl[t].lat0, tbl[t].lat1, tbl[t].lat2);
      chk("tbl_op_cycles", t, 64'(op_cycles), 64'(tbl[t].opc));
      chk("tbl_error", t, 64'(error), 64'(tbl[t].err));
      chk("tbl_err_op", t, 64'(err_op), 64'(tbl[t].errop));
    end

    for (int r = 0; r < 40; r++) begin
      int l[3];
      for (int i = 0; i < 3; i++)
        l[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 60));
      run_cmd(3'($urandom), l[0], l[1], l[2]);
    end

    // Directed: engine 0 write reaches memory one cycle later, engine 2 write is blocked
    do_reset();
    eng_we = 3'b000; eng_done = 3'b000;
    start = 1'b1; op_mask = 3'b101;
    step();
    start = 1'b0;
    step();
    chk("dir_launch0", 2, 64'(eng_start), 64'b001);
    step();
    eng_row = {AW'(9), AW'(0), AW'(5)};
    eng_col = {AW'(9), AW'(0), AW'(7)};
    eng_pix = {24'hFFFFFF, 24'h000000, 24'h00AB00};
    eng_we  = 3'b101;
    step();
    chk("dir_mem_row", 4, 64'(mem_row), 64'd5);
    chk("dir_mem_col", 4, 64'(mem_col), 64'd7);
    chk("dir_mem_pix", 4, 64'(mem_pix), 64'h00AB00);
    chk("dir_mem_we", 4, 64'(mem_we), 64'd1);
    eng_we = 3'b100;
    step();
    chk("dir_mem_we_other", 5, 64'(mem_we), 64'd0);

    // Directed: start while busy is ignored, reset mid-RUN of engine 1 aborts
    do_reset();
    eng_done = 3'b000; eng_we = 3'b000;
    start = 1'b1; op_mask = 3'b010;
    step();
    start = 1'b0;
    step();
    chk("dir_launch1", 2, 64'(eng_start), 64'b010);
    step();
    step();
    start = 1'b1; op_mask = 3'b111;
    step();
    chk("dir_busy_ignore", 5, 64'(busy), 64'd1);
    chk("dir_no_relaunch", 5, 64'(eng_start), 64'd0);
    chk("dir_opc_run", 5, 64'(op_cycles), 64'd2);
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
